// File: rtl/data_mem_port_if.sv
// Load/store request bus between the chain tail and the shared data-memory port.
interface data_mem_port_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic              st_en;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              st_full;
  logic              sq_empty;

  modport master (
    output ld_en, ld_addr, st_en, st_addr, st_data,
    input  ld_data, ld_valid, st_full, sq_empty
  );

  modport slave (
    input  ld_en, ld_addr, st_en, st_addr, st_data,
    output ld_data, ld_valid, st_full, sq_empty
  );
endinterface

// File: rtl/data_mem_port.sv
// Shared data-memory endpoint: single-port sync RAM, fixed 2-cycle loads,
// in-order store queue that drains on load-free cycles and forwards to loads.
module data_mem_port #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned SQ_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_port_if.slave  bus
);

  localparam int unsigned PW = $clog2(SQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] r_mem     [MEM_WORDS];
  logic [ADDR_W-1:0] r_sq_addr [SQ_DEPTH];
  logic [DATA_W-1:0] r_sq_data [SQ_DEPTH];

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              r_s1_valid;
  logic              r_s1_hit;
  logic [DATA_W-1:0] r_s1_fwd;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_ld_valid;
  logic [DATA_W-1:0] r_ld_data;

  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_drain;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd;

  assign w_full  = (r_count == CW'(SQ_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = bus.st_en && !w_full;
  assign w_drain = !w_empty && !bus.ld_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)   r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_sq_addr[r_tail] <= bus.st_addr;
      r_sq_data[r_tail] <= bus.st_data;
    end
  end

  // Single RAM port: a load always takes it, otherwise the queue head commits.
  always_ff @(posedge clk) begin
    if (bus.ld_en)
      r_rd_data <= r_mem[bus.ld_addr[IW-1:0]];
    else if (w_drain)
      r_mem[r_sq_addr[r_head][IW-1:0]] <= r_sq_data[r_head];
  end

  // Scan oldest to youngest so later matches override; the incoming store is youngest.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_sq_addr[r_head + PW'(i)] == bus.ld_addr)) begin
        w_hit = 1'b1;
        w_fwd = r_sq_data[r_head + PW'(i)];
      end
    end
    if (w_enq && (bus.st_addr == bus.ld_addr)) begin
      w_hit = 1'b1;
      w_fwd = bus.st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_fwd   <= '0;
      r_ld_valid <= 1'b0;
      r_ld_data  <= '0;
    end else begin
      r_s1_valid <= bus.ld_en;
      r_s1_hit   <= w_hit;
      r_s1_fwd   <= w_fwd;
      r_ld_valid <= r_s1_valid;
      if (r_s1_valid)
        r_ld_data <= r_s1_hit ? r_s1_fwd : r_rd_data;
    end
  end

  assign bus.ld_data  = r_ld_data;
  assign bus.ld_valid = r_ld_valid;
  assign bus.st_full  = w_full;
  assign bus.sq_empty = w_empty;

  a_no_store_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.st_en && w_full)
  );

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: latency, forwarding, queue full/drain, reset.
module tb_data_mem_port;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  data_mem_port_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  data_mem_port #(
    .DATA_W(16), .ADDR_W(16), .MEM_WORDS(4096), .SQ_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    bus.ld_en   = 1'b1;
    bus.ld_addr = addr;
    tick();
    bus.ld_en = 1'b0;
    bus.st_en = 1'b0;
    chk({tag, "_v1"}, 32'(bus.ld_valid), 32'd0);
    tick();
    chk({tag, "_v2"}, 32'(bus.ld_valid), 32'd1);
    chk({tag, "_d"},  32'(bus.ld_data),  32'(exp));
  endtask

  task automatic set_st(input logic [15:0] a, input logic [15:0] d);
    bus.st_en   = 1'b1;
    bus.st_addr = a;
    bus.st_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.ld_en = 1'b0; bus.ld_addr = '0;
    bus.st_en = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    tick(); tick();
    chk("rst_ld_valid", 32'(bus.ld_valid), 32'd0);
    chk("rst_ld_data",  32'(bus.ld_data),  32'd0);
    chk("rst_st_full",  32'(bus.st_full),  32'd0);
    chk("rst_sq_empty", 32'(bus.sq_empty), 32'd1);
    #2 rst_n = 1'b1;
    tick();

    // Preload 0x0010 through the queue, then plain RAM load.
    set_st(16'h0010, 16'h1234);
    tick();
    bus.st_en = 1'b0;
    tick(); tick(); tick();
    chk("preload_empty", 32'(bus.sq_empty), 32'd1);
    do_load(16'h0010, 16'h1234, "ld_ram");
    tick();
    chk("ld_ram_v3",   32'(bus.ld_valid), 32'd0);
    chk("ld_ram_hold", 32'(bus.ld_data),  32'h1234);

    // Forward from a queued store, then same load from RAM.
    set_st(16'h0020, 16'h00AA);
    tick();
    bus.st_en = 1'b0;
    do_load(16'h0020, 16'h00AA, "fwd_q");
    chk("fwd_q_empty", 32'(bus.sq_empty), 32'd1);
    repeat (6) tick();
    do_load(16'h0020, 16'h00AA, "ram_st");
    chk("ram_st_empty", 32'(bus.sq_empty), 32'd1);

    // Same-cycle store forwards to the load.
    set_st(16'h0030, 16'h0005);
    do_load(16'h0030, 16'h0005, "same_cyc");
    repeat (3) tick();

    // Youngest-wins with both entries held (loads block drain); alias does not forward.
    bus.ld_en = 1'b1; bus.ld_addr = 16'h0099;
    set_st(16'h0030, 16'h0001);
    tick();
    set_st(16'h0030, 16'h0002);
    tick();
    bus.st_en = 1'b0;
    bus.ld_addr = 16'h0030;
    tick();
    bus.ld_addr = 16'h1030;
    tick();
    chk("young_v", 32'(bus.ld_valid), 32'd1);
    chk("young_d", 32'(bus.ld_data),  32'h0002);
    bus.ld_en = 1'b0;
    tick();
    chk("alias_v", 32'(bus.ld_valid), 32'd1);
    chk("alias_d", 32'(bus.ld_data),  32'h0005);
    tick();
    chk("b2b_end_v", 32'(bus.ld_valid), 32'd0);
    repeat (4) tick();
    do_load(16'h0030, 16'h0002, "commit_ord");

    // Fill the queue under continuous loads, then drain one per cycle.
    bus.ld_en = 1'b1; bus.ld_addr = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      set_st(16'(16'h0040 + i), 16'(16'h0011 * (i + 1)));
      tick();
    end
    bus.st_en = 1'b0;
    chk("fill_full",  32'(bus.st_full),  32'd1);
    chk("fill_empty", 32'(bus.sq_empty), 32'd0);
    bus.ld_en = 1'b0;
    tick();
    chk("drain1_full", 32'(bus.st_full), 32'd0);
    tick(); tick();
    chk("drain3_empty", 32'(bus.sq_empty), 32'd0);
    tick();
    chk("drain4_empty", 32'(bus.sq_empty), 32'd1);
    for (int i = 0; i < 4; i++)
      do_load(16'(16'h0040 + i), 16'(16'h0011 * (i + 1)), "drain_ram");

    // Count 3 plus same-cycle load and store reaches full; loads keep forwarding.
    bus.ld_en = 1'b1; bus.ld_addr = 16'h0060;
    for (int i = 0; i < 3; i++) begin
      set_st(16'(16'h0050 + i), 16'(16'h00A0 + i));
      tick();
    end
    chk("c3_full", 32'(bus.st_full), 32'd0);
    set_st(16'h0053, 16'h00A3);
    bus.ld_addr = 16'h0051;
    tick();
    bus.st_en = 1'b0;
    chk("c4_full", 32'(bus.st_full), 32'd1);
    bus.ld_addr = 16'h0053;
    tick();
    chk("c4_ld_v", 32'(bus.ld_valid), 32'd1);
    chk("c4_ld_d", 32'(bus.ld_data),  32'h00A1);
    bus.ld_en = 1'b0;
    tick();
    chk("c5_ld_d", 32'(bus.ld_data), 32'h00A3);
    repeat (4) tick();
    chk("c4_drained", 32'(bus.sq_empty), 32'd1);
    do_load(16'h0053, 16'h00A3, "full_commit");

    // Reset between load issue and return.
    bus.ld_en = 1'b1; bus.ld_addr = 16'h0070;
    set_st(16'h0070, 16'h0077);
    tick();
    bus.ld_en = 1'b0; bus.st_en = 1'b0;
    chk("pre_rst_empty", 32'(bus.sq_empty), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_imm_empty", 32'(bus.sq_empty), 32'd1);
    chk("rst_imm_v",     32'(bus.ld_valid), 32'd0);
    tick();
    chk("rst_t1_v", 32'(bus.ld_valid), 32'd0);
    tick();
    chk("rst_t2_v", 32'(bus.ld_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_v",     32'(bus.ld_valid), 32'd0);
    chk("post_rst_empty", 32'(bus.sq_empty), 32'd1);
    chk("post_rst_data",  32'(bus.ld_data),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Shared data-memory endpoint at the tail of the per-core load/store request chain.
- Each core's select stage either forwards the chain's ld/st request or inserts its own. This block consumes the final request pair and services it against a single-port synchronous RAM.
- Load data returns with a fixed 2-cycle latency; select-stage ld_en pipelines depend on this.
- Stores go into a small in-order store queue. The queue drains into RAM on cycles with no load, and loads forward from it.

Parameters:
DATA_W, 16, data word width (tape cell width)
ADDR_W, 16, request address width
MEM_WORDS, 4096, RAM depth; effective index = addr modulo MEM_WORDS (power of two, low bits)
SQ_DEPTH, 4, store-queue entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ld_en  input  1  load request (chain tail ld_en_out)
ld_addr  input  ADDR_W  load address
st_en  input  1  store request (chain tail st_en_out)
st_addr  input  ADDR_W  store address
st_data  input  DATA_W  store data
ld_data  output  DATA_W  load result, valid when ld_valid
ld_valid  output  1  high exactly 2 cycles after an accepted ld_en
st_full  output  1  queue full; ORed into chain head st_en so no core issues a store
sq_empty  output  1  store queue empty (all stores committed); used for END/halt drain

Behaviour:
Reset (rst_n low, async):
- ld_data=0, ld_valid=0, st_full=0, sq_empty=1.
- Queue count, head and tail pointers =0; load pipeline valids =0.
- RAM contents are not reset.
- A reset asserted mid-operation discards queued stores and in-flight loads.

Store queue:
- Circular FIFO of {addr, data}, SQ_DEPTH entries; head/tail pointers wrap modulo SQ_DEPTH.
- Enqueue: st_en && !st_full.
- st_en while st_full: protocol violation; the store is dropped and a sim assertion fires.
- Drain: pop the head into RAM write on any cycle with count>0 and !ld_en. The popped entry is the entry present at the start of the cycle.
- Enqueue and drain in the same cycle: count unchanged.
- st_full = (count==SQ_DEPTH) and sq_empty = (count==0), both combinational from registered count.
- Same-cycle ld_en and st_en when count==SQ_DEPTH-1: the store enqueues, no drain occurs, count becomes SQ_DEPTH.

Load pipeline (fixed latency 2):
- Cycle T, ld_en: RAM sync read at ld_addr. Forward check runs against the T-start queue entries plus a same-cycle incoming store.
  - A same-cycle st_en counts as older than the load.
  - If multiple entries match, the youngest wins: incoming store, then entries from tail-1 back to head.
  - Record stage-1 {valid, fwd_hit, fwd_data}.
- Cycle T+1: stage-2 register latches fwd_hit ? fwd_data : RAM read data.
- Cycle T+2: ld_valid=1 and ld_data = that value.
- Back-to-back loads give one result per cycle. ld_valid deasserts the cycle after the last result. ld_data holds its last value otherwise.
- Address compare uses the full ADDR_W. RAM index uses the low log2(MEM_WORDS) bits, so aliasing addresses forward only on exact match.
- Load with no matching queued store and no RAM write to that index at T: returns the RAM content present at T.

Ordering and priority:
- A load never stalls; a load always wins the RAM port over a drain.
- Continuous loads starve draining. st_full then backpressures the chain; this is legal.
- Stores commit to RAM in program (enqueue) order.

Test Plan:
- Reset, then ld_en addr 0x0010 with RAM preloaded 0x1234 -> ld_valid=1 exactly at T+2 with ld_data=0x1234; ld_valid=0 at T+1 and T+3.
- st_en addr 0x0020 data 0x00AA, then load 0x0020 on the next cycle -> ld_data=0x00AA (forwarded; the store has not yet drained). The same load 6 idle cycles later returns 0x00AA from RAM, and sq_empty=1.
- Same-cycle st_en 0x0030/0x0005 and ld_en 0x0030 -> ld_data=0x0005 at T+2. Stores 0x0030/1 then 0x0030/2 followed by a load -> returns 2 (youngest wins).
- 4 stores while ld_en is held high every cycle -> st_full=1 after the 4th. Drop ld_en -> one drain per cycle, st_full=0 next cycle, sq_empty=1 after 4 cycles, and RAM holds all values in order.
- Full queue with ld_en and st_en in the same cycle at count 3 -> count 4, st_full=1, and the load result is correct at T+2.
- Assert rst_n low between a load issue and its return -> ld_valid stays 0, the queue is empty, and sq_empty=1 immediately.
